// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the per-thread branch resolver.
// Entry layout changes when BRANCH_RESOLVER_ANNUL_EN is defined (annul bit stored).
package branch_resolver_pkg;

  localparam int PC_WIDTH           = 10;
  localparam int THREAD_COUNT       = 8;
  localparam int THREAD_COUNT_WIDTH = 3;
  localparam int FLAG_COUNT         = 4;
  localparam int FLAG_SEL_WIDTH     = 2;
  localparam int COUNT_WIDTH        = 8;
  localparam int STAGE_COUNT        = 2;

  typedef struct packed {
    logic                      enable;
    logic                      negate;
    logic                      use_count;
`ifdef BRANCH_RESOLVER_ANNUL_EN
    logic                      annul;
`endif
    logic [FLAG_SEL_WIDTH-1:0] flag_sel;
    logic [PC_WIDTH-1:0]       origin;
    logic [PC_WIDTH-1:0]       destination;
    logic [COUNT_WIDTH-1:0]    count;
  } branch_entry_t;

  localparam branch_entry_t BRANCH_ENTRY_RESET = '0;

  // A flag index past the top flag shifts the mask out to zero, so it reads as 0.
  function automatic logic entry_cond(
    input logic                      use_count,
    input logic                      negate,
    input logic [FLAG_SEL_WIDTH-1:0] flag_sel,
    input logic [COUNT_WIDTH-1:0]    count,
    input logic [FLAG_COUNT-1:0]     flags
  );
    logic [FLAG_COUNT-1:0] mask;
    mask = FLAG_COUNT'(1) << flag_sel;
    if (use_count) return (count != '0);
    return (|(flags & mask)) ^ negate;
  endfunction

endpackage

// File: rtl/rr_thread_counter.sv
// Free-running round-robin thread index, 0 .. COUNT-1, restarting at INIT on reset.
module rr_thread_counter #(
  parameter int               COUNT = 8,
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clock,
  input  logic             reset,
  output logic [WIDTH-1:0] thread
);

  always_ff @(posedge clock) begin
    if (reset) begin
      thread <= INIT;
    end else if (thread == WIDTH'(COUNT - 1)) begin
      thread <= '0;
    end else begin
      thread <= thread + WIDTH'(1);
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Round-robin per-thread branch evaluator feeding jump/destination/cancel to the PC controller.
// Optional feature macro: BRANCH_RESOLVER_ANNUL_EN (per-entry annul bit driving cancel).
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int PC_WIDTH           = branch_resolver_pkg::PC_WIDTH,
  parameter int THREAD_COUNT       = branch_resolver_pkg::THREAD_COUNT,
  parameter int THREAD_COUNT_WIDTH = branch_resolver_pkg::THREAD_COUNT_WIDTH,
  parameter int FLAG_COUNT         = branch_resolver_pkg::FLAG_COUNT,
  parameter int FLAG_SEL_WIDTH     = branch_resolver_pkg::FLAG_SEL_WIDTH,
  parameter int COUNT_WIDTH        = branch_resolver_pkg::COUNT_WIDTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [PC_WIDTH-1:0]           pc,
  input  logic                          IO_ready,
  input  logic [FLAG_COUNT-1:0]         flags,
  input  logic                          cfg_wren,
  input  logic [THREAD_COUNT_WIDTH-1:0] cfg_thread,
  input  logic                          cfg_enable,
  input  logic                          cfg_negate,
  input  logic                          cfg_use_count,
  input  logic                          cfg_annul,
  input  logic [FLAG_SEL_WIDTH-1:0]     cfg_flag_sel,
  input  logic [PC_WIDTH-1:0]           cfg_origin,
  input  logic [PC_WIDTH-1:0]           cfg_destination,
  input  logic [COUNT_WIDTH-1:0]        cfg_count,
  output logic                          jump,
  output logic [PC_WIDTH-1:0]           jump_destination,
  output logic                          cancel,
  output logic [THREAD_COUNT_WIDTH-1:0] out_thread
);

  logic [THREAD_COUNT_WIDTH-1:0] rd_thread;
  logic [THREAD_COUNT_WIDTH-1:0] wb_thread;

  rr_thread_counter #(
    .COUNT (THREAD_COUNT),
    .WIDTH (THREAD_COUNT_WIDTH),
    .INIT  ('0)
  ) u_rd_counter (
    .clock  (clock),
    .reset  (reset),
    .thread (rd_thread)
  );

  // Trails the read thread by the pipeline depth so it names the thread being written back.
  rr_thread_counter #(
    .COUNT (THREAD_COUNT),
    .WIDTH (THREAD_COUNT_WIDTH),
    .INIT  (THREAD_COUNT_WIDTH'(THREAD_COUNT - STAGE_COUNT))
  ) u_wb_counter (
    .clock  (clock),
    .reset  (reset),
    .thread (wb_thread)
  );

  branch_entry_t entries [THREAD_COUNT];
  branch_entry_t rd_entry;
  branch_entry_t cfg_entry;

  assign rd_entry = entries[rd_thread];

  always_comb begin
    cfg_entry             = BRANCH_ENTRY_RESET;
    cfg_entry.enable      = cfg_enable;
    cfg_entry.negate      = cfg_negate;
    cfg_entry.use_count   = cfg_use_count;
    cfg_entry.flag_sel    = cfg_flag_sel;
    cfg_entry.origin      = cfg_origin;
    cfg_entry.destination = cfg_destination;
    cfg_entry.count       = cfg_count;
`ifdef BRANCH_RESOLVER_ANNUL_EN
    cfg_entry.annul       = cfg_annul;
`endif
  end

  logic cfg_hit_rd;
  logic cfg_hit_s1;

  // Stage 1: entry fields, match and condition for the thread just read.
  logic                          s1_match;
  logic                          s1_cond;
  logic                          s1_ready;
  logic                          s1_keep;
  logic                          s1_use_count;
  logic [PC_WIDTH-1:0]           s1_destination;
  logic [COUNT_WIDTH-1:0]        s1_count;
  logic [THREAD_COUNT_WIDTH-1:0] s1_thread;

  // Stage 2 bookkeeping for the counter write-back.
  logic                          s2_dec;
  logic [COUNT_WIDTH-1:0]        s2_count;
  logic                          taken;

  // A config write that lands after the read replaces the entry, so the in-flight decrement is dropped.
  assign cfg_hit_rd = cfg_wren && (cfg_thread == rd_thread);
  assign cfg_hit_s1 = cfg_wren && (cfg_thread == s1_thread);
  assign taken      = s1_match & s1_cond & s1_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < THREAD_COUNT; i++) begin
        entries[i] <= BRANCH_ENTRY_RESET;
      end
    end else begin
      if (s2_dec) begin
        entries[wb_thread].count <= s2_count;
      end
      if (cfg_wren) begin
        entries[cfg_thread] <= cfg_entry;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_match       <= 1'b0;
      s1_cond        <= 1'b0;
      s1_ready       <= 1'b0;
      s1_keep        <= 1'b0;
      s1_use_count   <= 1'b0;
      s1_destination <= '0;
      s1_count       <= '0;
      s1_thread      <= '0;
    end else begin
      s1_match       <= rd_entry.enable && (pc == rd_entry.origin);
      s1_cond        <= entry_cond(rd_entry.use_count, rd_entry.negate, rd_entry.flag_sel,
                                   rd_entry.count, flags);
      s1_ready       <= IO_ready;
      s1_keep        <= !cfg_hit_rd;
      s1_use_count   <= rd_entry.use_count;
      s1_destination <= rd_entry.destination;
      s1_count       <= rd_entry.count;
      s1_thread      <= rd_thread;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      jump             <= 1'b0;
      jump_destination <= '0;
      out_thread       <= '0;
      s2_dec           <= 1'b0;
      s2_count         <= '0;
    end else begin
      jump             <= taken;
      jump_destination <= taken ? s1_destination : '0;
      out_thread       <= s1_thread;
      s2_dec           <= taken && s1_use_count && s1_keep && !cfg_hit_s1;
      s2_count         <= s1_count - COUNT_WIDTH'(1);
    end
  end

`ifdef BRANCH_RESOLVER_ANNUL_EN
  logic s1_annul;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_annul <= 1'b0;
      cancel   <= 1'b0;
    end else begin
      s1_annul <= rd_entry.annul;
      cancel   <= taken & s1_annul;
    end
  end
`else
  logic unused_cfg_annul;

  assign unused_cfg_annul = cfg_annul;
  assign cancel           = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed and randomized checks of branch_resolver against a per-thread table model.
module tb_branch_resolver;

  localparam int NT = 8;
  localparam int W  = 15;  // {jump, destination[9:0], cancel, thread[2:0]}

`ifdef BRANCH_RESOLVER_ANNUL_EN
  localparam logic ANNUL_ON = 1'b1;
`else
  localparam logic ANNUL_ON = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic [9:0] pc;
  logic       IO_ready;
  logic [3:0] flags;
  logic       cfg_wren;
  logic [2:0] cfg_thread;
  logic       cfg_enable;
  logic       cfg_negate;
  logic       cfg_use_count;
  logic       cfg_annul;
  logic [1:0] cfg_flag_sel;
  logic [9:0] cfg_origin;
  logic [9:0] cfg_destination;
  logic [7:0] cfg_count;
  logic       jump;
  logic [9:0] jump_destination;
  logic       cancel;
  logic [2:0] out_thread;

  branch_resolver dut (
    .clock            (clock),
    .reset            (reset),
    .pc               (pc),
    .IO_ready         (IO_ready),
    .flags            (flags),
    .cfg_wren         (cfg_wren),
    .cfg_thread       (cfg_thread),
    .cfg_enable       (cfg_enable),
    .cfg_negate       (cfg_negate),
    .cfg_use_count    (cfg_use_count),
    .cfg_annul        (cfg_annul),
    .cfg_flag_sel     (cfg_flag_sel),
    .cfg_origin       (cfg_origin),
    .cfg_destination  (cfg_destination),
    .cfg_count        (cfg_count),
    .jump             (jump),
    .jump_destination (jump_destination),
    .cancel           (cancel),
    .out_thread       (out_thread)
  );

  // Clock and watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Reference model: branch table as plain arrays, thread index as an integer
  logic         m_en   [NT];
  logic         m_neg  [NT];
  logic         m_use  [NT];
  logic         m_ann  [NT];
  int           m_sel  [NT];
  logic [9:0]   m_org  [NT];
  logic [9:0]   m_dst  [NT];
  int           m_cnt  [NT];
  int           m_thread;
  logic [W-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      m_en[i] = 0; m_neg[i] = 0; m_use[i] = 0; m_ann[i] = 0;
      m_sel[i] = 0; m_org[i] = '0; m_dst[i] = '0; m_cnt[i] = 0;
    end
    m_thread = 0;
    exp_q.delete();
    exp_q.push_back('0);  // outputs of the zeroed stage 1 right after reset
  endtask

  function automatic logic model_taken(input int t, input logic [9:0] p, input logic r,
                                       input logic [3:0] f);
    logic cond;
    if (m_use[t]) cond = (m_cnt[t] != 0);
    else          cond = f[m_sel[t]] ^ m_neg[t];
    return m_en[t] && (p == m_org[t]) && cond && r;
  endfunction

  // Driver tasks
  task automatic set_cfg(input int t, input logic en, input logic neg, input logic use_c,
                         input logic ann, input logic [1:0] sel, input logic [9:0] org,
                         input logic [9:0] dst, input logic [7:0] cnt);
    cfg_wren = 1'b1; cfg_thread = 3'(t); cfg_enable = en; cfg_negate = neg;
    cfg_use_count = use_c; cfg_annul = ann; cfg_flag_sel = sel; cfg_origin = org;
    cfg_destination = dst; cfg_count = cnt;
  endtask

  // One cycle: present inputs for the model's current thread, advance, check the output two cycles old.
  task automatic step(input logic [9:0] p, input logic r, input logic [3:0] f);
    logic         tk;
    logic [W-1:0] e;
    int           t;
    t = m_thread;
    pc = p; IO_ready = r; flags = f;
    tk = model_taken(t, p, r, f);
    exp_q.push_back({tk, tk ? m_dst[t] : 10'd0, tk & m_ann[t] & ANNUL_ON, 3'(t)});
    if (tk && m_use[t]) m_cnt[t] = m_cnt[t] - 1;
    if (cfg_wren) begin
      m_en[cfg_thread] = cfg_enable; m_neg[cfg_thread] = cfg_negate;
      m_use[cfg_thread] = cfg_use_count; m_ann[cfg_thread] = cfg_annul;
      m_sel[cfg_thread] = int'(cfg_flag_sel); m_org[cfg_thread] = cfg_origin;
      m_dst[cfg_thread] = cfg_destination; m_cnt[cfg_thread] = int'(cfg_count);
    end
    m_thread = (m_thread + 1) % NT;
    @(posedge clock); #1;
    cfg_wren = 1'b0;
    e = exp_q.pop_front();
    check("jump", 32'(jump), 32'(e[14]));
    check("jump_destination", 32'(jump_destination), 32'(e[13:4]));
    check("cancel", 32'(cancel), 32'(e[3]));
    check("out_thread", 32'(out_thread), 32'(e[2:0]));
  endtask

  task automatic idle_until(input int t);
    while (m_thread != t) step(10'h3FF, 1'b0, 4'h0);
  endtask

  task automatic program_entry(input int t, input logic en, input logic neg, input logic use_c,
                               input logic ann, input logic [1:0] sel, input logic [9:0] org,
                               input logic [9:0] dst, input logic [7:0] cnt);
    set_cfg(t, en, neg, use_c, ann, sel, org, dst, cnt);
    step(10'h3FF, 1'b0, 4'h0);
  endtask

  // Present one instruction on thread t and check the directed jump outcome two cycles later.
  task automatic pass(input string tag, input int t, input logic [9:0] p, input logic r,
                      input logic [3:0] f, input logic exp_jump);
    idle_until(t);
    step(p, r, f);
    step(10'h3FF, 1'b0, 4'h0);
    check(tag, 32'(jump), 32'(exp_jump));
    check({tag, "_thread"}, 32'(out_thread), 32'(t));
  endtask

  logic [9:0] origins [4];
  int         jump_seen;

  initial begin
    origins[0] = 10'h010; origins[1] = 10'h020; origins[2] = 10'h030; origins[3] = 10'h040;
    reset = 1'b1; pc = '0; IO_ready = 1'b0; flags = '0;
    set_cfg(0, 0, 0, 0, 0, 2'd0, 10'h0, 10'h0, 8'h0);
    cfg_wren = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_jump", 32'(jump), 32'd0);
    check("reset_destination", 32'(jump_destination), 32'd0);
    check("reset_cancel", 32'(cancel), 32'd0);
    check("reset_out_thread", 32'(out_thread), 32'd0);
    reset = 1'b0;
    model_reset();

    // Flag branch on thread 2
    program_entry(2, 1, 0, 0, 0, 2'd1, 10'h040, 10'h100, 8'd0);
    pass("flag_taken", 2, 10'h040, 1'b1, 4'b0010, 1'b1);
    check("flag_taken_dest", 32'(jump_destination), 32'h100);
    pass("flag_clear", 2, 10'h040, 1'b1, 4'b0000, 1'b0);
    check("flag_clear_dest", 32'(jump_destination), 32'h000);
    program_entry(2, 1, 1, 0, 0, 2'd3, 10'h040, 10'h100, 8'd0);
    pass("flag_negated", 2, 10'h040, 1'b1, 4'b0111, 1'b1);
    pass("pc_mismatch", 2, 10'h041, 1'b1, 4'b0111, 1'b0);

    // Loop counter on thread 0
    program_entry(0, 1, 0, 1, 0, 2'd0, 10'h010, 10'h008, 8'd3);
    pass("loop_1", 0, 10'h010, 1'b1, 4'h0, 1'b1);
    check("loop_1_dest", 32'(jump_destination), 32'h008);
    pass("loop_2", 0, 10'h010, 1'b1, 4'h0, 1'b1);
    pass("loop_3", 0, 10'h010, 1'b1, 4'h0, 1'b1);
    pass("loop_4", 0, 10'h010, 1'b1, 4'h0, 1'b0);

    // Not-ready instruction never branches nor consumes the count
    program_entry(0, 1, 0, 1, 0, 2'd0, 10'h010, 10'h008, 8'd2);
    pass("stall", 0, 10'h010, 1'b0, 4'h0, 1'b0);
    pass("stall_then_1", 0, 10'h010, 1'b1, 4'h0, 1'b1);
    pass("stall_then_2", 0, 10'h010, 1'b1, 4'h0, 1'b1);
    pass("stall_then_3", 0, 10'h010, 1'b1, 4'h0, 1'b0);

    // Config write on the same edge as the decrement write-back: the write wins
    program_entry(0, 1, 0, 1, 0, 2'd0, 10'h010, 10'h008, 8'd1);
    idle_until(0);
    step(10'h010, 1'b1, 4'h0);
    step(10'h3FF, 1'b0, 4'h0);
    set_cfg(0, 1, 0, 1, 0, 2'd0, 10'h010, 10'h008, 8'd5);
    step(10'h3FF, 1'b0, 4'h0);
    for (int i = 0; i < 5; i++) pass("collide_taken", 0, 10'h010, 1'b1, 4'h0, 1'b1);
    pass("collide_exhausted", 0, 10'h010, 1'b1, 4'h0, 1'b0);

    // Annul
    program_entry(3, 1, 0, 0, 1, 2'd0, 10'h050, 10'h123, 8'd0);
    pass("annul_jump", 3, 10'h050, 1'b1, 4'b0001, 1'b1);
    check("annul_cancel", 32'(cancel), 32'(ANNUL_ON));
    pass("annul_not_taken", 3, 10'h050, 1'b1, 4'b0000, 1'b0);
    check("annul_not_taken_cancel", 32'(cancel), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        set_cfg(int'($urandom_range(0, NT - 1)), 1'($urandom_range(0, 7) != 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), origins[$urandom_range(0, 3)],
                10'($urandom_range(0, 1023)), 8'($urandom_range(0, 3)));
      end
      step(($urandom_range(0, 4) == 0) ? 10'($urandom_range(0, 1023)) : origins[$urandom_range(0, 3)],
           1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
    end

    // Reset while a taken branch sits in stage 1; a config write during reset is ignored
    program_entry(4, 1, 0, 0, 0, 2'd0, 10'h060, 10'h0AA, 8'd0);
    idle_until(4);
    step(10'h060, 1'b1, 4'h1);
    reset = 1'b1;
    set_cfg(5, 1, 0, 0, 0, 2'd0, 10'h070, 10'h0BB, 8'd0);
    @(posedge clock); #1;
    check("midreset_jump", 32'(jump), 32'd0);
    check("midreset_destination", 32'(jump_destination), 32'd0);
    check("midreset_cancel", 32'(cancel), 32'd0);
    check("midreset_out_thread", 32'(out_thread), 32'd0);
    reset = 1'b0;
    cfg_wren = 1'b0;
    model_reset();
    jump_seen = 0;
    for (int i = 0; i < NT + 2; i++) begin
      step((i == 4) ? 10'h060 : ((i == 5) ? 10'h070 : 10'h000), 1'b1, 4'hF);
      jump_seen += int'(jump);
    end
    check("post_reset_jumps", 32'(jump_seen), 32'd0);
    pass("post_reset_thread4", 4, 10'h060, 1'b1, 4'hF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
